// File: rtl/ysyx_20020207_alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   arb_state_t : FSM state encoding (IDLE/WAIT/RESP)
//   ALU_*       : 4-bit ALU op codes carried on req_ctrl / alu_ctrl
//   FLAG_*      : bit positions inside resp_flags ({branch, cf, of, zf})
// Optional feature macro used by the top: ALU_ARB_RR_EN (round-robin).
package ysyx_20020207_alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1101;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    localparam int FLAG_ZF = 0;
    localparam int FLAG_OF = 1;
    localparam int FLAG_CF = 2;
    localparam int FLAG_BR = 3;

endpackage

// File: rtl/ysyx_20020207_alu_arb_if.sv
// Bundle of every handshake/bus signal around the ALU arbiter.
//   request side : req_valid/req_ready, per-slot operands and control
//   ALU side     : alu_in_valid + muxed operands out, alu_out_valid + result/flags in
//   response side: resp_valid/resp_ready, shared resp_result/resp_flags
// Modports: slave = the arbiter, master = the surrounding issue logic and ALU.
interface ysyx_20020207_alu_arb_if #(parameter int W = 32);

    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [7:0]     req_ctrl;
    logic [1:0]     req_sub;
    logic [1:0]     req_sign;
    logic [1:0]     req_is_arch;

    logic           alu_in_valid;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [3:0]     alu_ctrl;
    logic           alu_sub;
    logic           alu_sign;
    logic           alu_is_arch;
    logic           alu_out_valid;
    logic [W-1:0]   alu_result;
    logic           alu_zf;
    logic           alu_of;
    logic           alu_cf;
    logic           alu_branch;

    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [W-1:0]   resp_result;
    logic [3:0]     resp_flags;

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, req_sub, req_sign, req_is_arch,
        input  alu_out_valid, alu_result, alu_zf, alu_of, alu_cf, alu_branch,
        input  resp_ready,
        output req_ready, alu_in_valid, alu_a, alu_b, alu_ctrl,
        output alu_sub, alu_sign, alu_is_arch,
        output resp_valid, resp_result, resp_flags
    );

    modport master (
        output req_valid, req_a, req_b, req_ctrl, req_sub, req_sign, req_is_arch,
        output alu_out_valid, alu_result, alu_zf, alu_of, alu_cf, alu_branch,
        output resp_ready,
        input  req_ready, alu_in_valid, alu_a, alu_b, alu_ctrl,
        input  alu_sub, alu_sign, alu_is_arch,
        input  resp_valid, resp_result, resp_flags
    );

endinterface

// File: rtl/ysyx_20020207_alu_arb_pick.sv
// Combinational two-way winner selection.
//   req_valid : per-slot request valid
//   prio      : favoured slot on a tie
//   gnt       : one-hot grant (all zero when nothing is valid)
//   win       : winner index; equals prio when nothing is valid
module ysyx_20020207_alu_arb_pick (
    input  logic [1:0] req_valid,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       win
);

    always_comb begin
        win = prio;
        if (!req_valid[prio] && req_valid[~prio])
            win = ~prio;
        gnt = '0;
        if (|req_valid)
            gnt[win] = 1'b1;
    end

endmodule

// File: rtl/ysyx_20020207_alu_arb.sv
// Two-requester arbiter/sequencer for the shared non-pipelined ALU.
// Accepts one op at a time, waits for alu_out_valid, then holds the
// captured result/flags for the owning slot until it is taken.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : request, ALU and response signals (slave modport)
// Macro ALU_ARB_RR_EN: round-robin between slots; otherwise slot 0 always
// wins ties (prio fixed at 0).
// Issue path (req_ready, alu_in_valid, alu_*) is combinational from state
// and req_valid; everything on the response side is registered.
module ysyx_20020207_alu_arb
    import ysyx_20020207_alu_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    ysyx_20020207_alu_arb_if.slave       bus
);

    arb_state_t state;
    logic       owner;
    logic       prio;
    logic [1:0] gnt;
    logic       win;
    logic       issue;
    logic [3:0] flags_in;

`ifdef ALU_ARB_RR_EN
    logic prio_q;
    assign prio = prio_q;
`else
    assign prio = 1'b0;
`endif

    ysyx_20020207_alu_arb_pick u_pick (
        .req_valid (bus.req_valid),
        .prio      (prio),
        .gnt       (gnt),
        .win       (win)
    );

    // Gated by reset_n so the issue side is quiet while reset is held.
    assign issue            = reset_n && (state == ST_IDLE) && (|bus.req_valid);
    assign bus.req_ready    = issue ? gnt : 2'b00;
    assign bus.alu_in_valid = issue;

    always_comb begin
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_ctrl    = '0;
        bus.alu_sub     = 1'b0;
        bus.alu_sign    = 1'b0;
        bus.alu_is_arch = 1'b0;
        if (issue) begin
            bus.alu_a       = win ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
            bus.alu_b       = win ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
            bus.alu_ctrl    = win ? bus.req_ctrl[7:4]  : bus.req_ctrl[3:0];
            bus.alu_sub     = bus.req_sub[win];
            bus.alu_sign    = bus.req_sign[win];
            bus.alu_is_arch = bus.req_is_arch[win];
        end
    end

    always_comb begin
        flags_in          = '0;
        flags_in[FLAG_ZF] = bus.alu_zf;
        flags_in[FLAG_OF] = bus.alu_of;
        flags_in[FLAG_CF] = bus.alu_cf;
        flags_in[FLAG_BR] = bus.alu_branch;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            owner           <= 1'b0;
            bus.resp_valid  <= '0;
            bus.resp_result <= '0;
            bus.resp_flags  <= '0;
`ifdef ALU_ARB_RR_EN
            prio_q          <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // alu_out_valid here is stray and deliberately ignored
                    if (issue) begin
                        owner <= win;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.alu_out_valid) begin
                        bus.resp_result <= bus.alu_result;
                        bus.resp_flags  <= flags_in;
                        bus.resp_valid  <= owner ? 2'b10 : 2'b01;
                        state           <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // result/flags hold until the owner takes them
                    if (bus.resp_ready[owner]) begin
                        bus.resp_valid <= '0;
                        state          <= ST_IDLE;
`ifdef ALU_ARB_RR_EN
                        prio_q         <= ~owner;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_20020207_alu_arb.md
# ysyx_20020207_alu_arb

Two-requester arbiter and sequencer for the single shared, non-pipelined 32-bit ALU. It accepts one operation at a time from either requester (slot 0 = EXU integer path, slot 1 = branch/address path) and drives the ALU's registered-input port. It waits for the ALU's one-cycle `out_valid`, then holds the result and flags for the owning requester until that requester takes them. It sits between the decode/issue logic and the ALU instance.

## Interface
- `W`, default 32: operand/result width; must match the ALU.
- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  2: per-slot request valid; bit i = slot i.
- `req_ready`  out  2: per-slot accept; a request transfers when valid and ready are both 1.
- `req_a`, `req_b`  in  2*W: per-slot operands; slot i is `[i*W +: W]`.
- `req_ctrl`  in  8: per-slot 4-bit ALU op code, `[i*4 +: 4]`.
- `req_sub`, `req_sign`, `req_is_arch`  in  2: per-slot control bits.
- `alu_in_valid`  out  1: issue strobe to the ALU.
- `alu_a`, `alu_b`  out  W: muxed operands.
- `alu_ctrl`  out  4: muxed op code.
- `alu_sub`, `alu_sign`, `alu_is_arch`  out  1: muxed control bits.
- `alu_out_valid`  in  1: ALU completion.
- `alu_result`  in  W: ALU result.
- `alu_zf`, `alu_of`, `alu_cf`, `alu_branch`  in  1: ALU flags and branch decision.
- `resp_valid`  out  2: per-slot response valid.
- `resp_ready`  in  2: per-slot response accept.
- `resp_result`  out  W: captured result, shared by both slots.
- `resp_flags`  out  4: captured `{branch, cf, of, zf}`.

## Operation
- FSM states are IDLE, WAIT and RESP. The `owner` register is 1 bit.
- **IDLE**
  - If any `req_valid` is set, pick a winner using the priority pointer `prio`, which names the favoured slot.
  - Assert `req_ready[winner]` and `alu_in_valid` in the same cycle, combinationally.
  - Drive `alu_*` from the winner's operands.
  - Latch `owner <= winner` and go to WAIT.
- **WAIT**
  - All `req_ready` are 0 and `alu_in_valid` is 0.
  - On `alu_out_valid`, capture `alu_result` and the flags into the response registers and go to RESP.
- **RESP**
  - `resp_valid[owner]` is 1; the other bit is 0.
  - On `resp_ready[owner]`: go to IDLE and set `prio <= ~owner`.
  - A new request is not accepted in this cycle.
- **Operand mux**
  - `alu_*` always reflect slot `prio` when only that slot or both slots are valid, and reflect the other slot when only it is valid.
  - `alu_*` values matter only while `alu_in_valid` is 1.
- **Boundary cases**
  - `alu_out_valid` seen in IDLE or RESP is ignored.
  - `resp_ready` on a non-owner bit is ignored.
  - Both slots valid in IDLE: slot `prio` wins; the loser's `req_valid` must stay asserted and is served next.
  - A requester that drops `req_valid` while not granted loses nothing.
- **Reset**
  - Applies in any state, including mid-WAIT.
  - Sets state to IDLE, `prio` to 0 and `owner` to 0, and clears the response registers.
  - A late `alu_out_valid` arriving after reset is ignored under the IDLE rule.

## Timing
- All outputs are 0 during and immediately after reset.
- `req_ready` and `alu_in_valid` are combinational from state and `req_valid`. All other outputs are registered.
- Latency:
  - Accept at cycle N.
  - ALU `out_valid` at N+1.
  - `resp_valid` at N+2.
  - With `resp_ready` held at 1, the next accept is at N+3.
  - Throughput is one operation per 3 cycles.
- Response stalls indefinitely while `resp_ready[owner]` is 0. `resp_result` and `resp_flags` stay stable throughout the stall.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. `prio` toggles to the non-owner after every completed response.
- `ALU_ARB_RR_EN` undefined: fixed priority. `prio` is tied to 0, so slot 0 always wins ties and slot 1 is served only when slot 0 is idle.

## Structure
- The shared package holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the ALU op-code constants (ADD 4'b0000 … BGEU 4'b1111);
  - the flag bit positions of `resp_flags`.
- One sub-module, `ysyx_20020207_alu_arb_pick`, is purely combinational. It takes `req_valid` and `prio` and produces a one-hot grant plus the winner index.
- FSM, muxing and response registers live in the top module.

## Test plan
- **Single request:** slot 0 issues ADD, a=5, b=7; ALU model returns 12 at N+1 → `resp_valid`=2'b01 at N+2, `resp_result`=12, `resp_flags`=4'b0000.
- **Simultaneous requests (RR build):** both slots valid in IDLE with `prio`=0 → slot 0 granted first; slot 1 granted at N+3; a third simultaneous pair grants slot 0 again.
- **Fixed-priority build:** slot 0 valid continuously while slot 1 is valid → slot 1 is never granted until slot 0 drops `req_valid`.
- **Response backpressure:** BEQ, a=b=3, ALU returns zf=1 and branch=1; `resp_ready` held 0 for 4 cycles → `resp_flags`=4'b1001 stable, no new `req_ready`, release completes on the cycle `resp_ready` rises.
- **Reset mid-operation:** `reset_n` driven low during WAIT, `alu_out_valid` arrives the following cycle → state is IDLE, `resp_valid`=0, no response delivered.
- **Stray completion:** `alu_out_valid` pulsed in IDLE → no `resp_valid`, response registers unchanged.
